dmem_arbiter: RTL and testbench

Round-robin arbiter that shares the single data-memory port among the cores of the multicore processor. Each core's MEM stage raises a request instead of driving memory directly. The arbiter grants one core at a time, sequences the memory access, and returns read data plus a completion strobe. It also drives a per-core stall back into that core's pipeline.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/rr_select.sv | 30 +++
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 tb/tb_dmem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;

  // Width of a core index; at least one bit even for a single core.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first requester at or after rr_ptr_i,
// searching upward modulo NUM_CORES.
module rr_select
  import dmem_arb_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  localparam int GRANT_W  = grant_w(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [GRANT_W-1:0]   rr_ptr_i,
  output logic [GRANT_W-1:0]   grant_o,
  output logic                 any_req_o
);

  // Walk the request vector starting at the pointer; keep the first hit.
  always_comb begin
    grant_o   = '0;
    any_req_o = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      int idx;
      idx = int'(rr_ptr_i) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!any_req_o && req_i[idx]) begin
        grant_o   = GRANT_W'(idx);
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous data-memory port among cores.
// Each access runs IDLE (arbitrate) -> ISSUE (mem_en) -> RESP (rvalid).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        core_req_i,
  input  logic [NUM_CORES-1:0]        core_we_i,
  input  logic [NUM_CORES-1:0]        core_half_i,
  input  logic [NUM_CORES-1:0]        core_byte_i,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr_i,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata_i,
  output logic [NUM_CORES-1:0]        core_rvalid_o,
  output logic [DATA_W-1:0]           core_rdata_o,
  output logic [NUM_CORES-1:0]        core_stall_o,
  output logic                        mem_en_o,
  output logic                        mem_we_o,
  output logic                        mem_half_o,
  output logic                        mem_byte_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  input  logic [DATA_W-1:0]           mem_rdata_i
);

  localparam int GRANT_W = grant_w(NUM_CORES);

  // Command captured at arbitration; later request changes cannot disturb it.
  typedef struct packed {
    logic [GRANT_W-1:0] grant;
    logic               we;
    logic               is_half;
    logic               is_byte;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
  } cmd_t;

  state_e               state_q, state_d;
  logic [GRANT_W-1:0]   rr_ptr_q, rr_ptr_d;
  cmd_t                 cmd_q, cmd_d;
  logic                 mem_en_q, mem_en_d;
  logic [NUM_CORES-1:0] rvalid_q, rvalid_d;

  logic [GRANT_W-1:0]   sel_grant;
  logic                 sel_any;

  rr_select #(.NUM_CORES(NUM_CORES)) u_rr_select (
    .req_i     (core_req_i),
    .rr_ptr_i  (rr_ptr_q),
    .grant_o   (sel_grant),
    .any_req_o (sel_any)
  );

  // Next-state, command capture, pointer advance and registered strobes.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cmd_d    = cmd_q;
    unique case (state_q)
      IDLE: begin
        if (sel_any) begin
          cmd_d.grant   = sel_grant;
          cmd_d.we      = core_we_i[sel_grant];
          cmd_d.is_half = core_half_i[sel_grant];
          cmd_d.is_byte = core_byte_i[sel_grant];
          cmd_d.addr    = core_addr_i[int'(sel_grant)*ADDR_W +: ADDR_W];
          cmd_d.wdata   = core_wdata_i[int'(sel_grant)*DATA_W +: DATA_W];
          state_d       = ISSUE;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        rr_ptr_d = (cmd_q.grant == GRANT_W'(NUM_CORES - 1)) ? '0 : cmd_q.grant + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so they line up with it.
    mem_en_d = (state_d == ISSUE);
    rvalid_d = '0;
    if (state_d == RESP) rvalid_d[cmd_q.grant] = 1'b1;
  end

  // State, pointer, command and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      // NOTE: the command register is reset as well, so every mem_* output reads 0 out of reset.
      cmd_q    <= '0;
      mem_en_q <= 1'b0;
      rvalid_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cmd_q    <= cmd_d;
      mem_en_q <= mem_en_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign mem_en_o      = mem_en_q;
  assign mem_we_o      = cmd_q.we;
  assign mem_half_o    = cmd_q.is_half;
  assign mem_byte_o    = cmd_q.is_byte;
  assign mem_addr_o    = cmd_q.addr;
  assign mem_wdata_o   = cmd_q.wdata;

  assign core_rvalid_o = rvalid_q;
  // Read data is passed through in the completion cycle of a load only.
  assign core_rdata_o  = (|rvalid_q && !cmd_q.we) ? mem_rdata_i : '0;
  // A core is held while requesting, except in its own completion cycle.
  assign core_stall_o  = core_req_i & ~rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level timing model and a shadow memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    core_req, core_we, core_half, core_byte;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [N-1:0]    core_rvalid, core_stall;
  logic [DW-1:0]   core_rdata;
  logic            mem_en, mem_we, mem_half, mem_byte;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;

  dmem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_half_i(core_half),
    .core_byte_i(core_byte), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata), .core_stall_o(core_stall),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_half_o(mem_half), .mem_byte_o(mem_byte),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents before any store: a fixed scramble of the address.
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Synchronous-read memory responding to the DUT's memory port.
  logic [31:0] mem [logic [31:0]];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      else mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : init_val(mem_addr);
    end else begin
      mem_rdata <= $urandom;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- per-core stimulus state ----------------
  bit          pend [N];
  bit          served [N];
  bit          autorep [N];
  logic        we_a [N], half_a [N], byte_a [N];
  logic [31:0] addr_a [N], wdata_a [N];
  bit          random_mode = 0;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      core_req[i]             = pend[i];
      core_we[i]              = we_a[i];
      core_half[i]            = half_a[i];
      core_byte[i]            = byte_a[i];
      core_addr[i*AW +: AW]   = addr_a[i];
      core_wdata[i*DW +: DW]  = wdata_a[i];
    end
  endtask

  task automatic post(input int i, input logic we, input logic h, input logic b,
                      input logic [31:0] a, input logic [31:0] d);
    pend[i] = 1; we_a[i] = we; half_a[i] = h; byte_a[i] = b; addr_a[i] = a; wdata_a[i] = d;
  endtask

  // ---------------- reference model ----------------
  // One access in flight at a time: granted at cycle t it is issued at t+1,
  // completes at t+2, and the arbiter looks again at t+3.
  int          cyc;
  int          m_ptr, m_issue, m_resp, m_free, m_g;
  logic        m_we, m_half, m_byte;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] shadow [logic [31:0]];

  int          obs_idx [$];
  int          obs_cyc [$];
  logic [31:0] obs_rd [$];

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_issue = -1; m_resp = -1; m_free = cyc;
    for (int i = 0; i < N; i++) begin pend[i] = 0; served[i] = 0; autorep[i] = 0; end
  endtask

  task automatic tick();
    logic [N-1:0] exp_rv;
    int w;
    #2;
    exp_rv = '0;
    if (cyc == m_resp) exp_rv[m_g] = 1'b1;
    check("mem_en", 64'(mem_en), 64'(cyc == m_issue));
    check("core_rvalid", 64'(core_rvalid), 64'(exp_rv));
    check("core_stall", 64'(core_stall), 64'(core_req & ~exp_rv));
    if (cyc == m_issue) begin
      check("mem_we", 64'(mem_we), 64'(m_we));
      check("mem_half", 64'(mem_half), 64'(m_half));
      check("mem_byte", 64'(mem_byte), 64'(m_byte));
      check("mem_addr", 64'(mem_addr), 64'(m_addr));
      check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
    if (|core_rvalid) begin
      for (int i = 0; i < N; i++) if (core_rvalid[i]) obs_idx.push_back(i);
      obs_cyc.push_back(cyc);
      obs_rd.push_back(core_rdata);
    end
    if (exp_rv != '0) begin
      check("core_rdata", 64'(core_rdata), 64'(m_we ? 32'h0 : model_rd(m_addr)));
      if (m_we) shadow[m_addr] = m_wdata;
      m_ptr = (m_g + 1) % N;
      served[m_g] = 0;
      if (!autorep[m_g]) pend[m_g] = 0;
    end
    if (cyc >= m_free && core_req != '0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        int idx = (m_ptr + k) % N;
        if (w < 0 && core_req[idx]) w = idx;
      end
      m_g = w; m_we = we_a[w]; m_half = half_a[w]; m_byte = byte_a[w];
      m_addr = addr_a[w]; m_wdata = wdata_a[w];
      m_issue = cyc + 1; m_resp = cyc + 2; m_free = cyc + 3;
      served[w] = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (random_mode) begin
      for (int i = 0; i < N; i++) begin
        if (served[i] && pend[i]) begin
          // Mid-transaction field changes and early drops must not matter.
          we_a[i] = 1'($urandom); addr_a[i] = $urandom; wdata_a[i] = $urandom;
          if ($urandom_range(7) == 0) pend[i] = 0;
        end else if (!pend[i] && !served[i] && $urandom_range(3) == 0) begin
          post(i, 1'($urandom), 1'($urandom), 1'($urandom),
               32'h200 + 32'($urandom_range(7)) * 4, $urandom);
        end
      end
    end
    drive();
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    bit busy = 1;
    while (busy && n < budget) begin
      busy = (cyc < m_free);
      for (int i = 0; i < N; i++) if (pend[i] || served[i]) busy = 1;
      if (busy) begin tick(); n++; end
    end
    if (busy) begin
      n_cmp++; n_err++;
      $error("FAIL timeout: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    model_reset();
    drive();
  endtask

  task automatic clear_obs();
    obs_idx.delete(); obs_cyc.delete(); obs_rd.delete();
  endtask

  initial begin
    int t;
    int g;
    cyc = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; served[i] = 0; autorep[i] = 0;
      we_a[i] = 0; half_a[i] = 0; byte_a[i] = 0; addr_a[i] = '0; wdata_a[i] = '0;
    end
    drive();
    mem[32'h40] = 32'hDEAD_BEEF;
    shadow[32'h40] = 32'hDEAD_BEEF;

    // Reset state: outputs 0, stall follows requests even in reset.
    rst_n = 1'b0;
    core_req = 4'b1010;
    repeat (2) @(posedge clk);
    #3;
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_rvalid", 64'(core_rvalid), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_mem_ctl", 64'({mem_we, mem_half, mem_byte}), 64'd0);
    check("rst_rdata", 64'(core_rdata), 64'd0);
    check("rst_stall", 64'(core_stall), 64'b1010);
    core_req = '0;
    do_reset();

    // Single load by core 2.
    clear_obs();
    post(2, 0, 0, 0, 32'h40, 32'h0);
    drive();
    t = cyc;
    run_until_idle(20);
    check("single_count", 64'(obs_idx.size()), 64'd1);
    if (obs_idx.size() == 1) begin
      check("single_core", 64'(obs_idx[0]), 64'd2);
      check("single_cyc", 64'(obs_cyc[0] - t), 64'd2);
      check("single_rdata", 64'(obs_rd[0]), 64'hDEAD_BEEF);
    end

    // All four from reset: grants 0,1,2,3, core 3 done at t+11.
    do_reset();
    clear_obs();
    for (int i = 0; i < N; i++) post(i, 0, 0, 0, 32'h80 + 32'(i) * 4, 32'h0);
    drive();
    t = cyc;
    run_until_idle(40);
    check("all4_count", 64'(obs_idx.size()), 64'd4);
    if (obs_idx.size() == 4) begin
      for (int i = 0; i < 4; i++) check("all4_order", 64'(obs_idx[i]), 64'(i));
      check("all4_last_cyc", 64'(obs_cyc[3] - t), 64'd11);
    end

    // Fairness: cores 0 and 3 keep requesting; grants must alternate.
    clear_obs();
    autorep[0] = 1; autorep[3] = 1;
    post(0, 0, 0, 0, 32'h10, 32'h0);
    post(3, 0, 0, 0, 32'h14, 32'h0);
    drive();
    g = 0;
    while (obs_idx.size() < 4 && g < 40) begin tick(); g++; end
    autorep[0] = 0; autorep[3] = 0;
    run_until_idle(40);
    check("fair_count_min", 64'(obs_idx.size() >= 4), 64'd1);
    if (obs_idx.size() >= 4) begin
      check("fair_g0", 64'(obs_idx[0]), 64'd0);
      check("fair_g1", 64'(obs_idx[1]), 64'd3);
      check("fair_g2", 64'(obs_idx[2]), 64'd0);
      check("fair_g3", 64'(obs_idx[3]), 64'd3);
    end

    // Store then load by core 1.
    clear_obs();
    post(1, 1, 0, 0, 32'h100, 32'h1234_5678);
    drive();
    run_until_idle(20);
    post(1, 0, 0, 0, 32'h100, 32'h0);
    drive();
    run_until_idle(20);
    check("sl_count", 64'(obs_idx.size()), 64'd2);
    if (obs_idx.size() == 2) begin
      check("sl_store_rdata", 64'(obs_rd[0]), 64'd0);
      check("sl_load_rdata", 64'(obs_rd[1]), 64'h1234_5678);
    end

    // Reset during ISSUE aborts the store.
    clear_obs();
    post(2, 1, 0, 0, 32'h300, 32'hAAAA_5555);
    drive();
    g = 0;
    while (cyc != m_issue && g < 10) begin tick(); g++; end
    #2;
    check("pre_rst_mem_en", 64'(mem_en), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_en", 64'(mem_en), 64'd0);
    check("mid_rst_rvalid", 64'(core_rvalid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    model_reset();
    drive();
    check("post_rst_state", 64'(dut.state_q), 64'(IDLE));
    check("post_rst_ptr", 64'(dut.rr_ptr_q), 64'd0);
    repeat (4) tick();
    check("post_rst_no_rvalid", 64'(obs_idx.size()), 64'd0);
    post(2, 0, 0, 0, 32'h300, 32'h0);
    drive();
    run_until_idle(20);
    check("aborted_store", 64'(obs_rd.size() == 1 ? obs_rd[0] : 32'h0), 64'(init_val(32'h300)));

    // Idle for 10 cycles, then a byte store from core 3.
    repeat (10) tick();
    post(3, 1, 0, 1, 32'h180, 32'h0000_00AB);
    drive();
    run_until_idle(20);

    // Random traffic with protocol abuse, checked by the model each cycle.
    random_mode = 1;
    repeat (400) tick();
    random_mode = 0;
    run_until_idle(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
